// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the alu issue controller and the alu it drives.
// Holds the alu opcodes and the controller state encoding.
package alu_issue_ctrl_pkg;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_MUL = 2'd2;
    localparam logic [1:0] ALU_SHL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC1 = 3'd1,
        ST_EXEC2 = 3'd2,
        ST_EXEC3 = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Command front end for the alu: issues one op, waits out the alu
// result and its late zero flag, returns both on a response port.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int N              = 8,
    parameter int width_of_index = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic         cmd_use_acc,
    input  logic         acc_clr,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_zero,
    output logic [N-1:0] alu_in1,
    output logic [N-1:0] alu_in2,
    output logic [1:0]   alu_op,
    input  logic [N-1:0] alu_out,
    input  logic [N-1:0] alu_z,
    output logic         busy,
    output logic [15:0]  op_count
);

    state_t       state_q;
    logic [N-1:0] in1_q;
    logic [N-1:0] in2_q;
    logic [1:0]   op_q;
    logic [N-1:0] data_q;
    logic         zero_q;
    logic         valid_q;
    logic [N-1:0] acc_q;
    logic [15:0]  cnt_q;

    // shift amount lives in the alu; upper z bits are never consulted
    logic unused_bits;
    assign unused_bits = ^alu_z[N-1:1] ^ width_of_index[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            in1_q   <= '0;
            in2_q   <= '0;
            op_q    <= ALU_ADD;
            data_q  <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (acc_clr) begin
                acc_q <= '0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        in2_q   <= cmd_b;
                        // a same-edge clear is forwarded to the operand
                        if (cmd_use_acc) begin
                            in1_q <= acc_clr ? '0 : acc_q;
                        end else begin
                            in1_q <= cmd_a;
                        end
                        state_q <= ST_EXEC1;
                    end
                end
                ST_EXEC1: begin
                    state_q <= ST_EXEC2;
                end
                ST_EXEC2: begin
                    data_q  <= alu_out;
                    acc_q   <= alu_out;
                    state_q <= ST_EXEC3;
                end
                ST_EXEC3: begin
                    zero_q  <= alu_z[0];
                    valid_q <= 1'b1;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= cnt_q + 16'd1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;
    assign rsp_zero  = zero_q;
    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign alu_op    = op_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl beside a behavioural alu.
// Directed cases plus randomized commands against an arithmetic model.
module tb_alu_issue_ctrl;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic         cmd_use_acc;
    logic         acc_clr;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_zero;
    logic [N-1:0] alu_in1;
    logic [N-1:0] alu_in2;
    logic [1:0]   alu_op;
    logic [N-1:0] alu_out;
    logic [N-1:0] alu_z;
    logic         busy;
    logic [15:0]  op_count;

    int checks;
    int failures;
    int model_acc;
    int exp_cnt;

    alu_issue_ctrl #(.N(N), .width_of_index(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc),
        .acc_clr(acc_clr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_zero(rsp_zero),
        .alu_in1(alu_in1),
        .alu_in2(alu_in2),
        .alu_op(alu_op),
        .alu_out(alu_out),
        .alu_z(alu_z),
        .busy(busy),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural alu: registered result, zero flag one cycle later
    always_ff @(posedge clk) begin
        case (alu_op)
            2'd0:    alu_out <= alu_in1 + alu_in2;
            2'd1:    alu_out <= alu_in1 - alu_in2;
            2'd2:    alu_out <= alu_in1 * alu_in2;
            default: alu_out <= alu_in1 << W;
        endcase
        alu_z <= {{(N-1){1'b0}}, (alu_out == '0)};
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_op(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b + 256;
            2:       r = a * b;
            default: r = a * 16;
        endcase
        return r % 256;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input int op, input int a, input int b,
                          input bit use_acc, input bit clr,
                          input int delay, input bit clr_e2,
                          input bit full);
        int n;
        int opa;
        int res;
        int hold;
        hold = 0;
        if (full) chk("cmd_ready_idle", int'(cmd_ready), 1);
        opa = use_acc ? (clr ? 0 : model_acc) : a;
        res = ref_op(op, opa, b);
        cmd_valid   = 1'b1;
        cmd_op      = 2'(op);
        cmd_a       = 8'(a);
        cmd_b       = 8'(b);
        cmd_use_acc = use_acc;
        acc_clr     = clr;
        tick();
        cmd_valid = 1'b0;
        acc_clr   = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            if (n == 1) acc_clr = clr_e2;
            tick();
            n++;
            if (n == 2) acc_clr = 1'b0;
        end
        if (full) chk("latency", n, 3);
        chk("rsp_data", int'(rsp_data), res);
        chk("rsp_zero", int'(rsp_zero), int'(res == 0));
        for (int i = 0; i < delay; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'($urandom);
            tick();
            if (!(rsp_valid && rsp_data == 8'(res) && !cmd_ready &&
                  int'(op_count) == exp_cnt % 65536))
                hold++;
        end
        cmd_valid = 1'b0;
        if (delay > 0) chk("stall_hold", hold, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_cnt++;
        model_acc = res;
        chk("op_count", int'(op_count), exp_cnt % 65536);
        if (full) begin
            chk("rsp_valid_drop", int'(rsp_valid), 0);
            chk("busy_drop", int'(busy), 0);
        end
    endtask

    initial begin
        int seen;
        checks      = 0;
        failures    = 0;
        model_acc   = 0;
        exp_cnt     = 0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_use_acc = 1'b0;
        acc_clr     = 1'b0;
        rsp_ready   = 1'b0;
        rst_n       = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_alu_in1", int'(alu_in1), 0);
        chk("rst_op_count", int'(op_count), 0);
        rst_n = 1'b1;
        tick();

        do_cmd(0, 3, 5, 0, 0, 0, 0, 1);
        do_cmd(1, 7, 7, 0, 0, 0, 0, 1);
        do_cmd(0, 1, 1, 0, 0, 0, 0, 1);
        do_cmd(2, 20, 13, 0, 0, 0, 0, 1);
        do_cmd(3, 8'h13, 0, 0, 0, 0, 0, 1);
        do_cmd(0, 2, 3, 0, 0, 0, 0, 1);
        do_cmd(0, 0, 10, 1, 0, 0, 0, 1);
        chk("acc_chain", model_acc, 15);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        model_acc = 0;
        do_cmd(0, 9, 1, 1, 0, 0, 0, 1);
        chk("acc_after_clr", model_acc, 1);
        do_cmd(0, 40, 2, 0, 0, 0, 1, 1);
        do_cmd(0, 0, 1, 1, 0, 0, 0, 1);
        chk("capture_wins", model_acc, 43);
        do_cmd(0, 0, 5, 1, 1, 0, 0, 1);
        do_cmd(1, 50, 7, 0, 0, 10, 0, 1);

        // random traffic
        for (int k = 0; k < 40; k++) begin
            do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), 1'($urandom),
                   ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                   1'($urandom), 0);
        end

        // reset while in EXEC2
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_a     = 8'd9;
        cmd_b     = 8'd9;
        cmd_use_acc = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
        chk("mid_rst_alu_in1", int'(alu_in1), 0);
        chk("mid_rst_alu_in2", int'(alu_in2), 0);
        chk("mid_rst_rsp_data", int'(rsp_data), 0);
        chk("mid_rst_op_count", int'(op_count), 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk("no_rsp_after_rst", seen, 0);
        chk("post_rst_op_count", int'(op_count), 0);
        exp_cnt   = 0;
        model_acc = 0;
        do_cmd(0, 0, 4, 1, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
